// File: rtl/psk_mode_ctrl.sv
// PSK mode controller: waits for loop lock, classifies BPSK/QPSK (or takes a forced
// mode), then packs per-symbol hard decisions into bytes behind a valid/ready port.
module psk_mode_ctrl #(
  parameter int unsigned ACQ_LEN   = 256,
  parameter int unsigned THR_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst_32M768_n,
  input  logic       lock,
  input  logic [1:0] cfg_mode,
  input  logic       det_vld,
  input  logic       det_bpsk,
  input  logic [1:0] det_qpsk,
  output logic       det_en,
  output logic       mode_vld,
  output logic       mode_qpsk,
  output logic [7:0] byte_data,
  output logic       byte_vld,
  input  logic       byte_rdy,
  output logic       overflow,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = $clog2(ACQ_LEN + 1);
  localparam int unsigned BIT_W = 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ACQ  = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  localparam logic [CNT_W-1:0] ACQ_END = CNT_W'(ACQ_LEN);
  localparam logic [CNT_W-1:0] OFF_THR = CNT_W'(ACQ_LEN >> THR_SHIFT);
  localparam logic [BIT_W-1:0] BYTE_BITS = BIT_W'(8);

  logic [1:0]       state_nxt;
  logic             det_en_nxt, mode_vld_nxt, mode_qpsk_nxt;
  logic [7:0]       byte_data_nxt;
  logic             byte_vld_nxt, overflow_nxt;
  logic [CNT_W-1:0] sym_cnt, sym_cnt_nxt, sym_inc;
  logic [CNT_W-1:0] off_cnt, off_cnt_nxt, off_inc;
  logic [7:0]       shreg, shreg_nxt, shift_in;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt, bit_inc;

  // Next-state and registered-output logic
  always_comb begin
    state_nxt     = state;
    det_en_nxt    = det_en;
    mode_vld_nxt  = mode_vld;
    mode_qpsk_nxt = mode_qpsk;
    byte_data_nxt = byte_data;
    byte_vld_nxt  = byte_vld;
    overflow_nxt  = overflow;
    sym_cnt_nxt   = sym_cnt;
    off_cnt_nxt   = off_cnt;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;

    sym_inc  = sym_cnt + CNT_W'(1);
    // BPSK constellation points only land in quadrants 00/11
    off_inc  = off_cnt + CNT_W'(det_qpsk[1] ^ det_qpsk[0]);
    shift_in = mode_qpsk ? {shreg[5:0], det_qpsk} : {shreg[6:0], det_bpsk};
    bit_inc  = bit_cnt + (mode_qpsk ? BIT_W'(2) : BIT_W'(1));

    if (byte_vld && byte_rdy) byte_vld_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (lock) begin
          det_en_nxt  = 1'b1;
          sym_cnt_nxt = '0;
          off_cnt_nxt = '0;
          shreg_nxt   = '0;
          bit_cnt_nxt = '0;
          if (cfg_mode == 2'b01 || cfg_mode == 2'b10) begin
            state_nxt     = S_RUN;
            mode_vld_nxt  = 1'b1;
            mode_qpsk_nxt = cfg_mode[1];
          end else begin
            state_nxt     = S_ACQ;
            mode_qpsk_nxt = 1'b0;
          end
        end
      end

      S_ACQ: begin
        if (!lock) begin
          state_nxt    = S_IDLE;
          det_en_nxt   = 1'b0;
          mode_vld_nxt = 1'b0;
          sym_cnt_nxt  = '0;
          off_cnt_nxt  = '0;
        end else if (det_vld) begin
          sym_cnt_nxt = sym_inc;
          off_cnt_nxt = off_inc;
          if (sym_inc == ACQ_END) begin
            mode_qpsk_nxt = (off_inc >= OFF_THR);
            mode_vld_nxt  = 1'b1;
            state_nxt     = S_RUN;
            sym_cnt_nxt   = '0;
            off_cnt_nxt   = '0;
            shreg_nxt     = '0;
            bit_cnt_nxt   = '0;
          end
        end
      end

      S_RUN: begin
        // A byte completing on the lock-loss edge is still delivered
        if (det_vld) begin
          shreg_nxt   = shift_in;
          bit_cnt_nxt = bit_inc;
          if (bit_inc == BYTE_BITS) begin
            bit_cnt_nxt = '0;
            if (byte_vld && !byte_rdy) begin
              overflow_nxt = 1'b1;
            end else begin
              byte_data_nxt = shift_in;
              byte_vld_nxt  = 1'b1;
            end
          end
        end
        if (!lock) begin
          state_nxt    = S_IDLE;
          det_en_nxt   = 1'b0;
          mode_vld_nxt = 1'b0;
          shreg_nxt    = '0;
          bit_cnt_nxt  = '0;
        end
      end

      default: begin
        state_nxt    = S_IDLE;
        det_en_nxt   = 1'b0;
        mode_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_32M768_n) begin
    if (!rst_32M768_n) begin
      state     <= S_IDLE;
      det_en    <= 1'b0;
      mode_vld  <= 1'b0;
      mode_qpsk <= 1'b0;
      byte_data <= '0;
      byte_vld  <= 1'b0;
      overflow  <= 1'b0;
      sym_cnt   <= '0;
      off_cnt   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      det_en    <= det_en_nxt;
      mode_vld  <= mode_vld_nxt;
      mode_qpsk <= mode_qpsk_nxt;
      byte_data <= byte_data_nxt;
      byte_vld  <= byte_vld_nxt;
      overflow  <= overflow_nxt;
      sym_cnt   <= sym_cnt_nxt;
      off_cnt   <= off_cnt_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
    end
  end

endmodule
